stopwatch_lap_ctrl: RTL and testbench

Controller for the stopwatch lap memory, a 30-deep x 28-bit register array with single-cycle write and asynchronous read through one shared address port.
It captures lap times into the array as a circular buffer and sequences a 30-cycle memory clear.
It also arbitrates the single address port between lap writes and lap-review reads, presenting the selected lap to the display path.
It sits between the stopwatch timekeeping/button logic and the lap memory.

---
 rtl/stopwatch_lap_ctrl.sv | 136 +++++++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_ctrl.sv
// Lap-memory controller: ring-buffer lap capture, full-memory clear sequencing,
// and arbitration of the single memory address port between writes and review reads.
module stopwatch_lap_ctrl #(
  parameter int DEPTH = 30,
  parameter int AW    = 5,
  parameter int DW    = 28
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iLap,
  input  logic [DW-1:0] iTime,
  input  logic          iClear,
  input  logic          iViewUp,
  input  logic          iViewDn,
  output logic          oMemWE,
  output logic [AW-1:0] oMemAddr,
  output logic [DW-1:0] oMemWData,
  input  logic [DW-1:0] iMemRData,
  output logic [DW-1:0] oLapData,
  output logic [AW-1:0] oLapIdx,
  output logic [AW-1:0] oCount,
  output logic          oFull,
  output logic          oBusy,
  output logic          oDrop
);

  localparam int            AW1     = AW + 1;
  localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LP_DEPTH = AW'(DEPTH);
  localparam logic [AW:0]   LP_DEPTH_W = AW1'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_CLEAR} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_view;
  logic [AW-1:0] r_count;
  logic [AW-1:0] r_clr_addr;
  logic [DW-1:0] r_lap_buf;
  logic [DW-1:0] r_lap_data;
  logic          r_drop;
  logic [AW:0]   w_raddr_sum;
  logic [AW-1:0] w_raddr;

  // Newest lap sits at wptr-1; adding DEPTH first keeps the subtraction non-negative.
  assign w_raddr_sum = {1'b0, r_wptr} + LP_DEPTH_W - AW1'(1) - {1'b0, r_view};
  assign w_raddr     = (w_raddr_sum >= LP_DEPTH_W) ? AW'(w_raddr_sum - LP_DEPTH_W)
                                                   : AW'(w_raddr_sum);

  always_ff @(posedge iClk) begin
    if (iRst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (iClear)    w_next_state = ST_CLEAR;
        else if (iLap) w_next_state = ST_WRITE;
      end
      ST_WRITE: w_next_state = ST_IDLE;
      ST_CLEAR: if (r_clr_addr == LP_LAST) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    oMemWE    = 1'b0;
    oMemAddr  = w_raddr;
    oMemWData = '0;
    case (r_state)
      ST_WRITE: begin
        oMemWE    = 1'b1;
        oMemAddr  = r_wptr;
        oMemWData = r_lap_buf;
      end
      ST_CLEAR: begin
        oMemWE   = 1'b1;
        oMemAddr = r_clr_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wptr     <= '0;
      r_view     <= '0;
      r_count    <= '0;
      r_clr_addr <= '0;
      r_lap_buf  <= '0;
      r_lap_data <= '0;
      r_drop     <= 1'b0;
    end else begin
      // A lap is lost whenever it cannot start a write: busy, or beaten by a clear.
      r_drop <= iLap & ((r_state != ST_IDLE) | iClear);
      case (r_state)
        ST_IDLE: begin
          r_lap_data <= (r_count != '0) ? iMemRData : '0;
          if (iClear) begin
            r_clr_addr <= '0;
          end else if (iLap) begin
            r_lap_buf <= iTime;
          end else if (r_count != '0 && iViewUp != iViewDn) begin
            if (iViewUp && (r_view + AW'(1) < r_count)) r_view <= r_view + AW'(1);
            if (iViewDn && (r_view != '0))             r_view <= r_view - AW'(1);
          end
        end
        ST_WRITE: begin
          r_wptr <= (r_wptr == LP_LAST) ? '0 : r_wptr + AW'(1);
          if (r_count != LP_DEPTH) r_count <= r_count + AW'(1);
          r_view <= '0;
        end
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + AW'(1);
          if (r_clr_addr == LP_LAST) begin
            r_wptr  <= '0;
            r_count <= '0;
            r_view  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign oLapData = r_lap_data;
  assign oLapIdx  = (r_count != '0) ? r_count - r_view : '0;
  assign oCount   = r_count;
  assign oFull    = (r_count == LP_DEPTH);
  assign oBusy    = (r_state != ST_IDLE);
  assign oDrop    = r_drop;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Bench for stopwatch_lap_ctrl: models the lap memory and checks the controller
// against a queue-based model of the stored laps and the review position.
module tb_stopwatch_lap_ctrl;

  localparam int DEPTH = 30;
  localparam int AW    = 5;
  localparam int DW    = 28;

  logic          iClk = 1'b0;
  logic          iRst, iLap, iClear, iViewUp, iViewDn;
  logic [DW-1:0] iTime;
  logic          oMemWE;
  logic [AW-1:0] oMemAddr;
  logic [DW-1:0] oMemWData;
  logic [DW-1:0] iMemRData;
  logic [DW-1:0] oLapData;
  logic [AW-1:0] oLapIdx, oCount;
  logic          oFull, oBusy, oDrop;

  stopwatch_lap_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .iClk(iClk), .iRst(iRst), .iLap(iLap), .iTime(iTime), .iClear(iClear),
    .iViewUp(iViewUp), .iViewDn(iViewDn), .oMemWE(oMemWE), .oMemAddr(oMemAddr),
    .oMemWData(oMemWData), .iMemRData(iMemRData), .oLapData(oLapData),
    .oLapIdx(oLapIdx), .oCount(oCount), .oFull(oFull), .oBusy(oBusy), .oDrop(oDrop)
  );

  always #5 iClk = ~iClk;

  // Lap memory: single-cycle write, asynchronous read.
  logic [DW-1:0] mem [DEPTH];
  assign iMemRData = mem[oMemAddr];

  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t wlog[$];
  int  drop_cnt = 0;

  always @(posedge iClk) begin
    if (oMemWE === 1'b1) begin
      mem[oMemAddr] <= oMemWData;
      wlog.push_back('{a: oMemAddr, d: oMemWData});
    end
    if (oDrop === 1'b1) drop_cnt++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stored laps oldest-first, laps written since the last clear, review offset.
  logic [DW-1:0] laps[$];
  int m_since = 0;
  int m_view  = 0;

  function automatic void model_reset();
    laps.delete(); m_since = 0; m_view = 0;
  endfunction

  function automatic int model_lap(input logic [DW-1:0] t);
    int a;
    a = m_since % DEPTH;
    if (laps.size() == DEPTH) void'(laps.pop_front());
    laps.push_back(t);
    m_since++;
    m_view = 0;
    return a;
  endfunction

  function automatic void model_view(input bit up, input bit dn);
    if (laps.size() == 0 || up == dn) return;
    if (up && m_view < laps.size() - 1) m_view++;
    if (dn && m_view > 0) m_view--;
  endfunction

  function automatic logic [DW-1:0] exp_data();
    return (laps.size() == 0) ? '0 : laps[laps.size() - 1 - m_view];
  endfunction

  function automatic logic [AW-1:0] exp_idx();
    return (laps.size() == 0) ? '0 : AW'(laps.size() - m_view);
  endfunction

  function automatic logic [AW-1:0] exp_raddr();
    return AW'((((m_since - 1 - m_view) % DEPTH) + DEPTH) % DEPTH);
  endfunction

  task automatic step();
    @(posedge iClk); #1;
  endtask

  task automatic apply_reset();
    iRst = 1'b1; step(); step(); iRst = 1'b0;
    model_reset();
    wlog.delete();
  endtask

  // Issue one lap pulse and wait until the new lap is visible on oLapData.
  task automatic do_lap(input logic [DW-1:0] t, output int exp_a);
    wlog.delete();
    iLap = 1'b1; iTime = t; step();
    iLap = 1'b0; step(); step();
    exp_a = model_lap(t);
    $display("lap time=%07h expected_addr=%0d writes=%0d", t, exp_a, wlog.size());
  endtask

  task automatic test_reset();
    iLap = 0; iClear = 0; iViewUp = 0; iViewDn = 0; iTime = '0;
    apply_reset();
    n_checks++; if (oMemWE !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b want=0", oMemWE); end
    n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", oBusy); end
    n_checks++; if (oFull !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b want=0", oFull); end
    n_checks++; if (oLapIdx !== '0) begin n_fail++; $display("FAIL reset_idx got=%0d want=0", oLapIdx); end
    n_checks++; if (oCount !== '0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", oCount); end
    n_checks++; if (oLapData !== '0) begin n_fail++; $display("FAIL reset_data got=%h want=0", oLapData); end
    n_checks++; if (oDrop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got=%b want=0", oDrop); end
  endtask

  task automatic test_basic_laps();
    logic [DW-1:0] tv [3];
    int ea;
    tv[0] = 28'h0000101; tv[1] = 28'h0000202; tv[2] = 28'h0000303;
    for (int i = 0; i < 3; i++) begin
      do_lap(tv[i], ea);
      n_checks++;
      if (wlog.size() != 1 || wlog[0].a !== AW'(ea) || wlog[0].d !== tv[i]) begin
        n_fail++;
        $display("FAIL basic_write%0d got_writes=%0d got_addr=%0d got_data=%h want 1 write addr=%0d data=%h",
                 i, wlog.size(), (wlog.size() > 0) ? wlog[0].a : '0, (wlog.size() > 0) ? wlog[0].d : '0, ea, tv[i]);
      end
    end
    n_checks++; if (oCount !== 5'd3) begin n_fail++; $display("FAIL basic_count got=%0d want=3", oCount); end
    n_checks++; if (oLapIdx !== 5'd3) begin n_fail++; $display("FAIL basic_idx got=%0d want=3", oLapIdx); end
    n_checks++; if (oLapData !== 28'h0000303) begin n_fail++; $display("FAIL basic_data got=%h want=0000303", oLapData); end
  endtask

  task automatic test_view();
    bit up, dn;
    for (int i = 0; i < 28; i++) begin
      // Directed up,up,up,dn first, then random pulses including both-at-once.
      if (i < 4) begin up = (i < 3); dn = (i == 3); end
      else begin up = 1'($urandom); dn = 1'($urandom); end
      iViewUp = up; iViewDn = dn; step();
      iViewUp = 0; iViewDn = 0;
      model_view(up, dn);
      n_checks++; if (oLapIdx !== exp_idx()) begin n_fail++; $display("FAIL view_idx%0d got=%0d want=%0d", i, oLapIdx, exp_idx()); end
      n_checks++; if (oMemAddr !== exp_raddr()) begin n_fail++; $display("FAIL view_raddr%0d got=%0d want=%0d", i, oMemAddr, exp_raddr()); end
      step();
      n_checks++; if (oLapData !== exp_data()) begin n_fail++; $display("FAIL view_data%0d got=%h want=%h", i, oLapData, exp_data()); end
    end
  endtask

  task automatic test_ring();
    int ea;
    apply_reset();
    for (int k = 1; k <= 32; k++) begin
      do_lap(DW'(k), ea);
      n_checks++;
      if (wlog.size() != 1 || wlog[0].a !== AW'((k - 1) % DEPTH) || wlog[0].d !== DW'(k)) begin
        n_fail++; $display("FAIL ring_write%0d writes=%0d want addr=%0d", k, wlog.size(), (k - 1) % DEPTH);
      end
      n_checks++; if (oFull !== (k >= DEPTH)) begin n_fail++; $display("FAIL ring_full%0d got=%b want=%b", k, oFull, k >= DEPTH); end
    end
    n_checks++; if (oCount !== 5'd30) begin n_fail++; $display("FAIL ring_count got=%0d want=30", oCount); end
    n_checks++; if (oLapData !== 28'd32) begin n_fail++; $display("FAIL ring_newest got=%0d want=32", oLapData); end
    for (int i = 0; i < 29; i++) begin
      iViewUp = 1; step(); iViewUp = 0; step();
      model_view(1, 0);
    end
    n_checks++; if (oLapData !== 28'd3 || exp_data() !== 28'd3) begin n_fail++; $display("FAIL ring_oldest got=%0d want=3", oLapData); end
    n_checks++; if (oLapIdx !== 5'd1) begin n_fail++; $display("FAIL ring_oldest_idx got=%0d want=1", oLapIdx); end
    iViewUp = 1; step(); iViewUp = 0; step();
    model_view(1, 0);
    n_checks++; if (oLapIdx !== exp_idx()) begin n_fail++; $display("FAIL ring_sat_idx got=%0d want=%0d", oLapIdx, exp_idx()); end
  endtask

  task automatic test_clear();
    int ea, busy, drop0, bad;
    apply_reset();
    for (int i = 0; i < 5; i++) do_lap(DW'($urandom), ea);
    drop0 = drop_cnt; wlog.delete();
    iClear = 1; step(); iClear = 0;
    busy = (oBusy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 32; i++) begin
      iLap = (i == 9); iTime = 28'hABCDEF0;
      step();
      if (oBusy === 1'b1) busy++;
    end
    iLap = 0;
    model_reset();
    bad = 0;
    for (int i = 0; i < wlog.size(); i++) if (wlog[i].a !== AW'(i) || wlog[i].d !== '0) bad++;
    $display("clear writes=%0d busy_cycles=%0d", wlog.size(), busy);
    n_checks++; if (wlog.size() != DEPTH || bad != 0) begin n_fail++; $display("FAIL clear_writes got=%0d bad=%0d want=30 bad=0", wlog.size(), bad); end
    n_checks++; if (busy != DEPTH) begin n_fail++; $display("FAIL clear_busy got=%0d want=30", busy); end
    n_checks++; if (drop_cnt - drop0 != 1) begin n_fail++; $display("FAIL clear_drop got=%0d want=1", drop_cnt - drop0); end
    n_checks++; if (oCount !== '0) begin n_fail++; $display("FAIL clear_count got=%0d want=0", oCount); end
    n_checks++; if (oLapIdx !== '0) begin n_fail++; $display("FAIL clear_idx got=%0d want=0", oLapIdx); end
    n_checks++; if (oLapData !== '0) begin n_fail++; $display("FAIL clear_data got=%h want=0", oLapData); end
  endtask

  task automatic test_lap_clear_same();
    int ea, drop0, bad;
    do_lap(DW'($urandom), ea); do_lap(DW'($urandom), ea);
    drop0 = drop_cnt; wlog.delete();
    iLap = 1; iClear = 1; iTime = 28'h1234567; step();
    iLap = 0; iClear = 0;
    repeat (32) step();
    model_reset();
    bad = 0;
    for (int i = 0; i < wlog.size(); i++) if (wlog[i].d !== '0) bad++;
    n_checks++; if (wlog.size() != DEPTH || bad != 0) begin n_fail++; $display("FAIL same_writes got=%0d nonzero=%0d want=30 nonzero=0", wlog.size(), bad); end
    n_checks++; if (drop_cnt - drop0 != 1) begin n_fail++; $display("FAIL same_drop got=%0d want=1", drop_cnt - drop0); end
    n_checks++; if (oCount !== '0) begin n_fail++; $display("FAIL same_count got=%0d want=0", oCount); end
  endtask

  task automatic test_back_to_back();
    int ea, drop0;
    logic [DW-1:0] t;
    t = DW'($urandom);
    drop0 = drop_cnt; wlog.delete();
    iLap = 1; iTime = t; step();
    iTime = ~t; step();
    iLap = 0; step(); step();
    ea = model_lap(t);
    n_checks++; if (wlog.size() != 1 || wlog[0].d !== t || wlog[0].a !== AW'(ea)) begin n_fail++; $display("FAIL b2b_writes got=%0d want 1 write of %h at %0d", wlog.size(), t, ea); end
    n_checks++; if (drop_cnt - drop0 != 1) begin n_fail++; $display("FAIL b2b_drop got=%0d want=1", drop_cnt - drop0); end
    n_checks++; if (oCount !== AW'(laps.size())) begin n_fail++; $display("FAIL b2b_count got=%0d want=%0d", oCount, laps.size()); end
    n_checks++; if (oLapData !== exp_data()) begin n_fail++; $display("FAIL b2b_data got=%h want=%h", oLapData, exp_data()); end
  endtask

  task automatic test_reset_mid_clear();
    int ea;
    logic [DW-1:0] t;
    for (int i = 0; i < 3; i++) do_lap(DW'($urandom), ea);
    iClear = 1; step(); iClear = 0;
    repeat (11) step();
    iRst = 1; step(); iRst = 0;
    model_reset(); wlog.delete();
    repeat (5) step();
    n_checks++; if (wlog.size() != 0) begin n_fail++; $display("FAIL rstclr_writes got=%0d want=0", wlog.size()); end
    n_checks++; if (oCount !== '0) begin n_fail++; $display("FAIL rstclr_count got=%0d want=0", oCount); end
    n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL rstclr_busy got=%b want=0", oBusy); end
    t = DW'($urandom);
    do_lap(t, ea);
    n_checks++; if (wlog.size() != 1 || wlog[0].a !== '0 || wlog[0].d !== t) begin n_fail++; $display("FAIL rstclr_lap writes=%0d want 1 write of %h at 0", wlog.size(), t); end
    n_checks++; if (oCount !== 5'd1) begin n_fail++; $display("FAIL rstclr_lapcount got=%0d want=1", oCount); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    iRst = 1; iLap = 0; iClear = 0; iViewUp = 0; iViewDn = 0; iTime = '0;
    test_reset();
    test_basic_laps();
    test_view();
    test_ring();
    test_view();
    test_clear();
    test_lap_clear_same();
    test_back_to_back();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
